data_bus_arbiter: RTL and testbench

Shares the single SoC data bus (RAM/ROM/LED decode path) between two masters: m0 (CPU data port) and m1 (debug/boot loader or DMA master).
Round-robin arbitration with registered grant, optional bus lock for back-to-back transfers, a bounded lock length, and a slave-timeout that completes hung transfers with an error.
Sits between the masters and the existing address decoder; the slave side presents one request/acknowledge port to the decoder.

---
 rtl/data_bus_arbiter_pkg.sv | 27 ++
 rtl/data_bus_arbiter_timeout.sv | 41 ++++
 rtl/data_bus_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter_pkg
// Purpose  : Shared types and constants for the two-master data bus arbiter:
//            ownership state encoding, one-hot grant codes, default limits.
// Revision : 1.0 - initial release
// ============================================================================
package data_bus_arbiter_pkg;

  // Bus ownership states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // One-hot grant codes presented on the grant output
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Default limits
  localparam int DEF_MAX_LOCK = 8;
  localparam int DEF_TIMEOUT  = 16;

endpackage : data_bus_arbiter_pkg
`default_nettype wire

// File: rtl/data_bus_arbiter_timeout.sv
`default_nettype none
// ============================================================================
// Module   : bus_timeout_counter
// Purpose  : Counts consecutive cycles a transfer is outstanding. Raises a
//            one-cycle 'expired' pulse on the TIMEOUT-th enabled cycle and
//            restarts from zero; 'clear' restarts it at any time.
// Revision : 1.0 - initial release
// ============================================================================
module bus_timeout_counter
  import data_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Expiry is purely combinational so the owner is completed in the same cycle
  assign expired = enable && (count == LAST);

  // Cycle counter: restarts on clear or on its own expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule : bus_timeout_counter
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Purpose  : Round-robin arbiter sharing one slave data bus between two
//            masters. Registered grant, optional bus lock with a bounded
//            length while the other master waits, and a slave timeout that
//            completes a hung transfer with an error.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = DEF_MAX_LOCK,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_wen,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  // master 1
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wen,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  // slave side
  output logic          s_req,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic [3:0]    s_wen,
  input  logic          s_ack,
  input  logic [DW-1:0] s_rdata,
  // current owner
  output logic [1:0]    grant
);

  // lock_cnt only needs to reach MAX_LOCK-1; one extra value keeps it safe
  localparam int             LCW       = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

  arb_state_t     state;
  arb_state_t     state_next;
  logic           rr;
  logic           rr_next;
  logic [LCW-1:0] lock_cnt;
  logic [LCW-1:0] lock_next;

  logic           own_req;
  logic           own_lock;
  logic           other_req;
  logic           other_idx;
  arb_state_t     other_state;

  logic           done_ok;
  logic           done;
  logic           tmo_clear;
  logic           tmo_enable;
  logic           tmo_expired;

  // Owner-relative view of the two masters
  always_comb begin
    own_req     = 1'b0;
    own_lock    = 1'b0;
    other_req   = 1'b0;
    other_idx   = 1'b0;
    other_state = ST_IDLE;
    case (state)
      ST_OWN0: begin
        own_req     = m0_req;
        own_lock    = m0_lock;
        other_req   = m1_req;
        other_idx   = 1'b1;
        other_state = ST_OWN1;
      end
      ST_OWN1: begin
        own_req     = m1_req;
        own_lock    = m1_lock;
        other_req   = m0_req;
        other_idx   = 1'b0;
        other_state = ST_OWN0;
      end
      default: ;
    endcase
  end

  // Slave-side mux: owner's request passes straight through; idle bus is all zero
  always_comb begin
    s_req   = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wen   = 4'b0000;
    case (state)
      ST_OWN0: begin
        s_req   = m0_req;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wen   = m0_req ? m0_wen : 4'b0000;
      end
      ST_OWN1: begin
        s_req   = m1_req;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wen   = m1_req ? m1_wen : 4'b0000;
      end
      default: ;
    endcase
  end

  // A stray s_ack with no request outstanding never completes anything
  assign done_ok    = s_req && s_ack;
  assign tmo_enable = s_req && !s_ack;
  assign tmo_clear  = !s_req || s_ack;
  assign done       = done_ok || tmo_expired;

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Completion responses routed to the current owner only
  always_comb begin
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    if (done) begin
      if (state == ST_OWN0) begin
        m0_ack   = 1'b1;
        m0_err   = tmo_expired;
        m0_rdata = done_ok ? s_rdata : '0;
      end else if (state == ST_OWN1) begin
        m1_ack   = 1'b1;
        m1_err   = tmo_expired;
        m1_rdata = done_ok ? s_rdata : '0;
      end
    end
  end

  // Registered grant decoded from the ownership state
  always_comb begin
    grant = GRANT_NONE;
    case (state)
      ST_OWN0: grant = GRANT_M0;
      ST_OWN1: grant = GRANT_M1;
      default: grant = GRANT_NONE;
    endcase
  end

  // Next ownership, round-robin pointer and lock-length tracking
  always_comb begin
    state_next = state;
    rr_next    = rr;
    lock_next  = lock_cnt;
    case (state)
      ST_IDLE: begin
        lock_next = '0;
        if (m0_req && m1_req) begin
          state_next = rr ? ST_OWN1 : ST_OWN0;
        end else if (m0_req) begin
          state_next = ST_OWN0;
        end else if (m1_req) begin
          state_next = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req) begin
          // Owner abandoned its request: release the bus without an ack
          state_next = ST_IDLE;
          lock_next  = '0;
        end else if (done) begin
          if (own_lock && !other_req) begin
            // Uncontended lock: keep the bus, nothing to count against
            lock_next = '0;
          end else if (own_lock && (lock_cnt < LOCK_LAST)) begin
            lock_next = lock_cnt + LCW'(1);
          end else begin
            rr_next    = other_idx;
            lock_next  = '0;
            state_next = other_req ? other_state : ST_IDLE;
          end
        end else if (!other_req) begin
          lock_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        lock_next  = '0;
      end
    endcase
  end

  // State, pointer and lock counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr       <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      rr       <= rr_next;
      lock_cnt <= lock_next;
    end
  end

endmodule : data_bus_arbiter
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Purpose  : Directed self-checking bench for data_bus_arbiter with a simple
//            slave responder (programmable ack delay, or no ack at all).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wen, m1_wen;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wen;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic [1:0]  grant;

  int          tests = 0;
  int          fails = 0;

  // slave responder controls (written by the main sequence only)
  bit          slave_en;
  int          slave_delay;
  logic [31:0] slave_data;
  int          wait_cnt;

  data_bus_arbiter #(
    .AW(32), .DW(32), .MAX_LOCK(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wen(m0_wen), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wen(m1_wen), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant(grant)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // slave: acks after slave_delay cycles of s_req, drives slave_data always
  initial begin
    s_ack    = 1'b0;
    s_rdata  = 32'h0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      s_rdata = slave_data;
      if (s_req === 1'b1 && slave_en) begin
        if (wait_cnt >= slave_delay) begin
          s_ack    = 1'b1;
          wait_cnt = 0;
        end else begin
          s_ack    = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        s_ack    = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // global time limit
  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of sequence, expected finish");
    $fatal(1, "time limit expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // advance cycle by cycle until master m acks; n = cycles advanced
  task automatic wait_ack(input int m, input int limit, input string tag, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= limit && !seen; i++) begin
      @(negedge clk);
      #3;
      n    = i;
      seen = (m == 0) ? (m0_ack === 1'b1) : (m1_ack === 1'b1);
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    int n;
    int cnt;
    rst_n = 1'b0;
    m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_wen = 0;
    m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_wen = 0;
    slave_en = 1'b1; slave_delay = 2; slave_data = 32'hDEADBEEF;

    // ---- reset values
    @(negedge clk); @(negedge clk); #3;
    check("rst_grant",    64'(grant),    64'd0);
    check("rst_s_req",    64'(s_req),    64'd0);
    check("rst_s_wen",    64'(s_wen),    64'd0);
    check("rst_s_addr",   64'(s_addr),   64'd0);
    check("rst_acks",     64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    check("rst_rdata",    64'({m0_rdata, m1_rdata}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // ---- single m0 read, slave acks 2 cycles later
    @(negedge clk); m0_req = 1; m0_addr = 32'h10000004; m0_wen = 4'b0000; #3;
    check("t1_grant_idle", 64'(grant), 64'b00);
    @(negedge clk); #3;
    check("t1_grant",  64'(grant),  64'b01);
    check("t1_s_req",  64'(s_req),  64'd1);
    check("t1_s_addr", 64'(s_addr), 64'h10000004);
    wait_ack(0, 8, "t1_ack", n);
    check("t1_latency", 64'(n), 64'd2);
    check("t1_rdata",   64'(m0_rdata), 64'hDEADBEEF);
    check("t1_err",     64'(m0_err),   64'd0);
    check("t1_m1_ack",  64'(m1_ack),   64'd0);
    @(negedge clk); m0_req = 0; #3;
    check("t1_back_idle", 64'(grant), 64'b00);

    // ---- reset pulsed mid-transfer (pointer currently favours m1)
    @(negedge clk); m0_req = 1; #3;
    @(negedge clk); #3;
    check("rst_mid_grant_before", 64'(grant), 64'b01);
    rst_n = 1'b0;
    #1;
    check("rst_mid_grant_async", 64'(grant), 64'b00);
    check("rst_mid_s_req",       64'(s_req),  64'd0);
    check("rst_mid_no_ack",      64'(m0_ack), 64'd0);
    @(negedge clk); #3;
    check("rst_mid_no_ack_later", 64'(m0_ack), 64'd0);
    @(negedge clk); rst_n = 1'b1; m0_req = 0;

    // ---- simultaneous requests: m0 first (pointer back to 0), m1 with no gap
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h10000010;
    m1_req = 1; m1_addr = 32'h30000020; #3;
    @(negedge clk); #3;
    check("t2_grant_m0_first", 64'(grant), 64'b01);
    wait_ack(0, 8, "t2_m0_ack", n);
    check("t2_m1_waiting", 64'(m1_ack), 64'd0);
    @(negedge clk); m0_req = 0; #3;
    check("t2_grant_m1_nogap", 64'(grant),  64'b10);
    check("t2_s_addr_m1",      64'(s_addr), 64'h30000020);
    wait_ack(1, 8, "t2_m1_ack", n);
    check("t2_m1_rdata", 64'(m1_rdata), 64'hDEADBEEF);
    @(negedge clk); m1_req = 0; #3;
    check("t2_idle", 64'(grant), 64'b00);

    // ---- slave never acks: error completion on the 16th s_req cycle
    slave_en = 1'b0; slave_data = 32'hFFFFFFFF;
    @(negedge clk); m0_req = 1; m0_addr = 32'h10000008; #3;
    @(negedge clk); #3;
    check("t4_s_req_rise", 64'(s_req), 64'd1);
    wait_ack(0, 30, "t4_tmo_ack", n);
    check("t4_tmo_cycles", 64'(n + 1), 64'd16);
    check("t4_tmo_err",    64'(m0_err),   64'd1);
    check("t4_tmo_rdata",  64'(m0_rdata), 64'd0);
    @(negedge clk); m0_req = 0; slave_en = 1'b1; slave_data = 32'h0000CAFE; #3;
    check("t4_idle", 64'(grant), 64'b00);

    // ---- second simultaneous pair: pointer now favours m1
    @(negedge clk); m0_req = 1; m1_req = 1; #3;
    @(negedge clk); #3;
    check("t2b_grant_m1_first", 64'(grant), 64'b10);
    wait_ack(1, 8, "t2b_m1_ack", n);
    check("t2b_m1_err",   64'(m1_err),   64'd0);
    check("t2b_m1_rdata", 64'(m1_rdata), 64'h0000CAFE);
    @(negedge clk); m1_req = 0; #3;
    check("t2b_grant_m0", 64'(grant), 64'b01);
    wait_ack(0, 8, "t2b_m0_ack", n);
    check("t2b_m0_err_clear", 64'(m0_err), 64'd0);
    @(negedge clk); m0_req = 0;

    // ---- m1 write
    @(negedge clk);
    m1_req = 1; m1_addr = 32'h20000000; m1_wen = 4'b1111; m1_wdata = 32'h5; #3;
    @(negedge clk); #3;
    check("t5_grant",   64'(grant),   64'b10);
    check("t5_s_wen",   64'(s_wen),   64'b1111);
    check("t5_s_wdata", 64'(s_wdata), 64'h5);
    wait_ack(1, 8, "t5_ack", n);
    @(negedge clk); m1_req = 0; m1_wen = 4'b0000; #3;
    check("t5_idle_grant", 64'(grant), 64'b00);
    check("t5_idle_s_wen", 64'(s_wen), 64'b0000);

    // ---- owner drops its request without completion
    @(negedge clk); m0_req = 1; #3;
    @(negedge clk); #3;
    check("pv_grant", 64'(grant), 64'b01);
    @(negedge clk); m0_req = 0; #3;
    check("pv_s_req",  64'(s_req),  64'd0);
    check("pv_no_ack", 64'(m0_ack), 64'd0);
    @(negedge clk); #3;
    check("pv_idle", 64'(grant), 64'b00);

    // ---- lock: m1 keeps bus for 8 transfers while m0 waits
    slave_delay = 0;
    @(negedge clk); m1_req = 1; m1_lock = 1; #3;
    @(negedge clk); m0_req = 1; #3;
    check("t3_grant_m1", 64'(grant), 64'b10);
    cnt = (m1_ack === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && grant !== 2'b01; i++) begin
      @(negedge clk); #3;
      if (grant === 2'b10 && m1_ack === 1'b1) cnt++;
    end
    check("t3_m1_locked_xfers", 64'(cnt),    64'd8);
    check("t3_handover_m0",     64'(grant),  64'b01);
    check("t3_m0_served",       64'(m0_ack), 64'd1);
    // m0 now idle: m1 keeps the bus for all 20 transfers
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m0_req = 0;
      #3;
      if (grant === 2'b10 && m1_ack === 1'b1) cnt++;
    end
    check("t3_m1_uncontended", 64'(cnt), 64'd20);
    @(negedge clk); m1_req = 0; m1_lock = 0; #3;
    check("t3_release_no_ack", 64'(m1_ack), 64'd0);
    @(negedge clk); #3;
    check("t3_idle", 64'(grant), 64'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_data_bus_arbiter
`default_nettype wire
